// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters, the issue-stage reservation port,
// and the register file write port driven by regfile_write_arbiter.
interface regfile_write_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   localparam int NREG = 1 << ADDR_W;

   logic              wb0_valid;
   logic              wb0_ready;
   logic [ADDR_W-1:0] wb0_rd;
   logic [DATA_W-1:0] wb0_data;

   logic              wb1_valid;
   logic              wb1_ready;
   logic [ADDR_W-1:0] wb1_rd;
   logic [DATA_W-1:0] wb1_data;

   logic              rsv_valid;
   logic [ADDR_W-1:0] rsv_rd;
   logic [NREG-1:0]   busy;

   logic              WE3;
   logic [ADDR_W-1:0] A3;
   logic [DATA_W-1:0] WD3;

   modport master (
      output wb0_valid, wb0_rd, wb0_data,
      input  wb0_ready,
      output wb1_valid, wb1_rd, wb1_data,
      input  wb1_ready,
      output rsv_valid, rsv_rd,
      input  busy, WE3, A3, WD3
   );

   modport slave (
      input  wb0_valid, wb0_rd, wb0_data,
      output wb0_ready,
      input  wb1_valid, wb1_rd, wb1_data,
      output wb1_ready,
      input  rsv_valid, rsv_rd,
      output busy, WE3, A3, WD3
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and
// load-return writeback paths, with a registered port stage and busy scoreboard.
module regfile_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input logic                   clk,
   input logic                   rst_n,
   regfile_write_arbiter_if.slave bus
);
   localparam int NREG = 1 << ADDR_W;

   logic              ptr;
   logic              contended;
   logic              grant0;
   logic              grant1;
   logic              xfer;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;
   logic [NREG-1:0]   set_mask;
   logic [NREG-1:0]   clr_mask;

   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [NREG-1:0]   busy_q;

   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment,
      // so no path leaves a value unassigned and no latch is inferred.
      set_mask  = '0;
      clr_mask  = '0;
      contended = bus.wb0_valid & bus.wb1_valid;
      grant0    = bus.wb0_valid & (~bus.wb1_valid | ~ptr);
      grant1    = bus.wb1_valid & (~bus.wb0_valid |  ptr);
      xfer      = grant0 | grant1;
      sel_rd    = grant1 ? bus.wb1_rd   : bus.wb0_rd;
      sel_data  = grant1 ? bus.wb1_data : bus.wb0_data;
      if (bus.rsv_valid && bus.rsv_rd != '0) set_mask[bus.rsv_rd] = 1'b1;
      if (we_q) clr_mask[addr_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the scoreboard is a flop vector rather than a RAM, so it is
      // reset with the rest of the state; a memory array would not be.
      if (!rst_n) begin
         ptr    <= 1'b0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         busy_q <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every flop samples the
         // pre-edge values regardless of statement order.
         if (contended) ptr <= ~ptr;
         we_q <= xfer && (sel_rd != '0);
         if (xfer) begin
            addr_q <= sel_rd;
            data_q <= sel_data;
         end
         // A newer reservation of the register being written wins over the clear.
         busy_q <= (busy_q & ~clr_mask) | set_mask;
      end
   end

   assign bus.wb0_ready = grant0;
   assign bus.wb1_ready = grant1;
   assign bus.WE3       = we_q;
   assign bus.A3        = addr_q;
   assign bus.WD3       = data_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter: handshake, round-robin
// fairness, registered port stage, busy scoreboard and asynchronous reset.
module tb_regfile_write_arbiter;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 2 time units after the rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      bus.wb0_valid = 1'b0;
      bus.wb0_rd    = '0;
      bus.wb0_data  = '0;
      bus.wb1_valid = 1'b0;
      bus.wb1_rd    = '0;
      bus.wb1_data  = '0;
      bus.rsv_valid = 1'b0;
      bus.rsv_rd    = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      #3;
      n_cmp++;
      if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1 ^ 1'b1, 5'd0, 32'd0}) begin
         n_err++;
         $display("FAIL reset_port: got WE3=%b A3=%0d WD3=%h, want 0/0/0", bus.WE3, bus.A3, bus.WD3);
      end
      n_cmp++;
      if (bus.busy !== 32'd0) begin
         n_err++;
         $display("FAIL reset_busy: got %h, want 0", bus.busy);
      end
      n_cmp++;
      if ({bus.wb0_ready, bus.wb1_ready} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_ready: got %b, want 00", {bus.wb0_ready, bus.wb1_ready});
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      bus.wb0_valid = 1'b1;
      bus.wb0_rd    = 5'd5;
      bus.wb0_data  = 32'hDEADBEEF;
      #1;
      n_cmp++;
      if ({bus.wb0_ready, bus.wb1_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL single_ready: got %b, want 10", {bus.wb0_ready, bus.wb1_ready});
      end
      step();
      bus.wb0_valid = 1'b0;
      n_cmp++;
      if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         n_err++;
         $display("FAIL single_write: got WE3=%b A3=%0d WD3=%h, want 1/5/deadbeef", bus.WE3, bus.A3, bus.WD3);
      end
      step();
      n_cmp++;
      if ({bus.WE3, bus.A3, bus.WD3} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
         n_err++;
         $display("FAIL single_idle: got WE3=%b A3=%0d WD3=%h, want 0/5/deadbeef", bus.WE3, bus.A3, bus.WD3);
      end
   endtask

   task automatic test_contention();
      logic [1:0]  exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
      logic [4:0]  exp_a3  [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
      logic [31:0] exp_wd  [4] = '{32'h11, 32'h22, 32'h11, 32'h22};
      bus.wb0_valid = 1'b1;
      bus.wb0_rd    = 5'd1;
      bus.wb0_data  = 32'h11;
      bus.wb1_valid = 1'b1;
      bus.wb1_rd    = 5'd2;
      bus.wb1_data  = 32'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if ({bus.wb0_ready, bus.wb1_ready} !== exp_rdy[i]) begin
            n_err++;
            $display("FAIL contend_ready[%0d]: got %b, want %b", i, {bus.wb0_ready, bus.wb1_ready}, exp_rdy[i]);
         end
         step();
         n_cmp++;
         if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, exp_a3[i], exp_wd[i]}) begin
            n_err++;
            $display("FAIL contend_write[%0d]: got WE3=%b A3=%0d WD3=%h, want 1/%0d/%h", i, bus.WE3, bus.A3, bus.WD3, exp_a3[i], exp_wd[i]);
         end
      end
      idle_inputs();
      step();
      n_cmp++;
      if (bus.WE3 !== 1'b0) begin
         n_err++;
         $display("FAIL contend_drain: got WE3=%b, want 0", bus.WE3);
      end
   endtask

   task automatic test_uncontended_ptr();
      bus.wb1_valid = 1'b1;
      bus.wb1_rd    = 5'd3;
      bus.wb1_data  = 32'h33;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if ({bus.wb0_ready, bus.wb1_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL solo1_ready[%0d]: got %b, want 01", i, {bus.wb0_ready, bus.wb1_ready});
         end
         step();
      end
      n_cmp++;
      if ({bus.WE3, bus.A3} !== {1'b1, 5'd3}) begin
         n_err++;
         $display("FAIL solo1_write: got WE3=%b A3=%0d, want 1/3", bus.WE3, bus.A3);
      end
      bus.wb0_valid = 1'b1;
      bus.wb0_rd    = 5'd4;
      bus.wb0_data  = 32'h44;
      #1;
      n_cmp++;
      if ({bus.wb0_ready, bus.wb1_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL ptr_kept_ready: got %b, want 10", {bus.wb0_ready, bus.wb1_ready});
      end
      step();
      n_cmp++;
      if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, 5'd4, 32'h44}) begin
         n_err++;
         $display("FAIL ptr_kept_write: got WE3=%b A3=%0d WD3=%h, want 1/4/44", bus.WE3, bus.A3, bus.WD3);
      end
      #1;
      n_cmp++;
      if ({bus.wb0_ready, bus.wb1_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL ptr_toggle_ready: got %b, want 01", {bus.wb0_ready, bus.wb1_ready});
      end
      step();
      idle_inputs();
      step();
   endtask

   task automatic test_scoreboard();
      bus.rsv_valid = 1'b1;
      bus.rsv_rd    = 5'd7;
      step();
      bus.rsv_valid = 1'b0;
      n_cmp++;
      if (bus.busy !== 32'h0000_0080) begin
         n_err++;
         $display("FAIL rsv_set: got busy=%h, want 00000080", bus.busy);
      end
      bus.wb0_valid = 1'b1;
      bus.wb0_rd    = 5'd7;
      bus.wb0_data  = 32'h77;
      step();
      bus.wb0_valid = 1'b0;
      n_cmp++;
      if ({bus.WE3, bus.A3, bus.busy} !== {1'b1, 5'd7, 32'h0000_0080}) begin
         n_err++;
         $display("FAIL wr7_pending: got WE3=%b A3=%0d busy=%h, want 1/7/00000080", bus.WE3, bus.A3, bus.busy);
      end
      step();
      n_cmp++;
      if (bus.busy !== 32'd0) begin
         n_err++;
         $display("FAIL wr7_clear: got busy=%h, want 0", bus.busy);
      end
      // Reserve twice, then collide a new reservation with the clearing write.
      bus.rsv_valid = 1'b1;
      step();
      step();
      bus.rsv_valid = 1'b0;
      n_cmp++;
      if (bus.busy !== 32'h0000_0080) begin
         n_err++;
         $display("FAIL rsv_twice: got busy=%h, want 00000080", bus.busy);
      end
      bus.wb0_valid = 1'b1;
      step();
      bus.wb0_valid = 1'b0;
      bus.rsv_valid = 1'b1;
      step();
      bus.rsv_valid = 1'b0;
      n_cmp++;
      if (bus.busy !== 32'h0000_0080) begin
         n_err++;
         $display("FAIL set_wins: got busy=%h, want 00000080", bus.busy);
      end
      bus.wb0_valid = 1'b1;
      step();
      bus.wb0_valid = 1'b0;
      step();
      n_cmp++;
      if (bus.busy !== 32'd0) begin
         n_err++;
         $display("FAIL rewrite_clear: got busy=%h, want 0", bus.busy);
      end
   endtask

   task automatic test_x0();
      bus.wb0_valid = 1'b1;
      bus.wb0_rd    = 5'd0;
      bus.wb0_data  = 32'hABCD_0000;
      bus.rsv_valid = 1'b1;
      bus.rsv_rd    = 5'd0;
      #1;
      n_cmp++;
      if (bus.wb0_ready !== 1'b1) begin
         n_err++;
         $display("FAIL x0_ready: got %b, want 1", bus.wb0_ready);
      end
      step();
      idle_inputs();
      n_cmp++;
      if ({bus.WE3, bus.A3, bus.WD3, bus.busy} !== {1'b0, 5'd0, 32'hABCD_0000, 32'd0}) begin
         n_err++;
         $display("FAIL x0_drop: got WE3=%b A3=%0d WD3=%h busy=%h, want 0/0/abcd0000/0", bus.WE3, bus.A3, bus.WD3, bus.busy);
      end
      step();
      n_cmp++;
      if ({bus.WE3, bus.busy} !== {1'b0, 32'd0}) begin
         n_err++;
         $display("FAIL x0_after: got WE3=%b busy=%h, want 0/0", bus.WE3, bus.busy);
      end
   endtask

   task automatic test_reset_mid();
      bus.wb0_valid = 1'b1;
      bus.wb0_rd    = 5'd9;
      bus.wb0_data  = 32'hCAFE_F00D;
      bus.rsv_valid = 1'b1;
      bus.rsv_rd    = 5'd9;
      step();
      idle_inputs();
      n_cmp++;
      if ({bus.WE3, bus.A3, bus.busy} !== {1'b1, 5'd9, 32'h0000_0200}) begin
         n_err++;
         $display("FAIL prereset: got WE3=%b A3=%0d busy=%h, want 1/9/00000200", bus.WE3, bus.A3, bus.busy);
      end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.WE3, bus.A3, bus.WD3, bus.busy} !== {1'b0, 5'd0, 32'd0, 32'd0}) begin
         n_err++;
         $display("FAIL async_reset: got WE3=%b A3=%0d WD3=%h busy=%h, want all 0", bus.WE3, bus.A3, bus.WD3, bus.busy);
      end
      step();
      rst_n         = 1'b1;
      bus.wb1_valid = 1'b1;
      bus.wb1_rd    = 5'd6;
      #1;
      n_cmp++;
      if ({bus.wb0_ready, bus.wb1_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL post_reset_ready: got %b, want 01", {bus.wb0_ready, bus.wb1_ready});
      end
      bus.wb1_valid = 1'b0;
      step();
      n_cmp++;
      if ({bus.WE3, bus.A3, bus.WD3} !== {1'b0, 5'd0, 32'd0}) begin
         n_err++;
         $display("FAIL post_reset_nowrite: got WE3=%b A3=%0d WD3=%h, want 0/0/0", bus.WE3, bus.A3, bus.WD3);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_single();
      test_contention();
      test_uncontended_ptr();
      test_scoreboard();
      test_x0();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port (WE3/A3/WD3) between two writeback requesters, the ALU writeback path (requester 0) and the load-return path (requester 1), using round-robin arbitration with a valid/ready handshake and one registered output stage. It also maintains a 32-entry busy scoreboard, so the issue stage can stall on registers with writes still in flight. The block sits between the execute/memory stages and the register file, and drives the register file write port directly.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- wb0_valid  in  1  requester 0 (ALU) has a write
- wb0_ready  out  1  requester 0 write accepted this cycle
- wb0_rd  in  ADDR_W  requester 0 destination register
- wb0_data  in  DATA_W  requester 0 write data
- wb1_valid / wb1_ready / wb1_rd / wb1_data  same as above, for requester 1 (load return)
- rsv_valid  in  1  issue stage reserves a destination register
- rsv_rd  in  ADDR_W  register to mark busy
- busy  out  32  per-register pending-write flags; bit 0 always 0
- WE3  out  1  register file write enable (registered)
- A3  out  ADDR_W  register file write address (registered)
- WD3  out  DATA_W  register file write data (registered)

## Operation
- Handshake:
  - A transfer occurs on a rising edge when valid and ready are both 1.
  - A requester holds valid, rd and data stable until it sees ready.
- Arbitration (combinational from valids and the priority pointer `ptr`):
  - Only wb0 valid: wb0_ready=1.
  - Only wb1 valid: wb1_ready=1.
  - Both valid: grant the requester selected by `ptr`; the other sees ready=0.
  - At most one ready is high in any cycle.
  - ready is never asserted for an invalid requester.
  - ready does not depend on the output stage; the output stage drains every cycle, so the port never back-pressures.
- Priority pointer:
  - `ptr` reset value is 0 (requester 0 preferred).
  - `ptr` toggles only on a contended grant: it points to the loser afterwards.
  - An uncontended grant leaves `ptr` unchanged.
- Output stage, on the edge where a transfer occurs:
  - A3 <= rd, WD3 <= data.
  - WE3 <= 1 if rd != 0, else WE3 <= 0 (writes to x0 are accepted and dropped).
- Output stage, on the edge with no transfer: WE3 <= 0; A3 and WD3 hold their values.
- Scoreboard:
  - rsv_valid with rsv_rd != 0 sets busy[rsv_rd] on the edge.
  - A cycle with WE3=1 clears busy[A3] on the edge that ends that cycle.
  - Simultaneous set and clear of the same index: set wins, because a newer reservation supersedes the older write.
  - A reservation of x0 is ignored.
  - Setting an already-busy bit is legal; the bit stays 1 (no counting).
- Reset (asynchronous):
  - WE3=0, A3=0, WD3=0, busy=0, ptr=0.
  - An in-flight output-stage write is discarded.
  - ready outputs follow the valids combinationally as soon as rst_n is released.

## Timing
- Accept latency: a transfer on edge N drives WE3/A3/WD3 during cycle N+1; the register file captures the write on edge N+1.
- Scoreboard clear: the busy bit falls on edge N+1, in the same edge as the register file write. Read data and busy=0 are therefore consistent from cycle N+2.
- Throughput: one write per cycle in total.
- Fairness under continuous contention: requesters strictly alternate, so the worst-case wait is 1 cycle.
- Reserve-to-busy latency: 1 edge.
- No combinational path from wb*_valid to WE3/A3/WD3.

## Test plan
- Reset, then wb0_valid=1, rd=5, data=0xDEADBEEF for one cycle -> wb0_ready=1 that cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF; the cycle after that, WE3=0.
- Both valid continuously for 4 cycles (wb0 rd=1, wb1 rd=2) -> grants 0,1,0,1; A3 sequence 1,2,1,2 one cycle later; the losing requester holds its request.
- wb1 alone for 3 cycles, then both valid -> ptr is still 0, so wb0 wins the first contended cycle.
- rsv_valid with rsv_rd=7 -> busy[7]=1 next cycle. Then a wb0 write to rd=7 is accepted on edge N -> busy[7]=0 after edge N+1. A repeat with rsv_rd=7 asserted in the WE3 cycle -> busy[7] stays 1.
- wb0 write to rd=0 and rsv_rd=0 -> wb0_ready=1, WE3 stays 0, busy stays 0.
- Accept a write, then assert rst_n=0 mid-cycle before the next edge -> WE3, A3, WD3 and busy go to 0 immediately; no write occurs after reset is released.
